// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions, datapath
// widths and the prefetch state encoding used by the fetch stage.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    // Opcode map (ir[15:12]).
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_BNE  = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_HLT  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_BLT  = 4'b1111;

    // Instruction field bit positions.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int RT_HI  = 7;
    localparam int RT_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Prefetch FSM encoding.
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    function automatic logic [3:0] ir_opcode(input logic [15:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Resolve-cycle decision: given the freshly loaded opcode and the ALU flags,
// decide whether the PC is redirected (branch/jump) or the core halts.
module branch_resolve #(
    parameter int PC_W = 8
) (
    input  logic            en,
    input  logic [3:0]      opcode,
    input  logic            alu_eq,
    input  logic            alu_gt,
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      imm8,
    output logic            pc_load,
    output logic [PC_W-1:0] next_pc,
    output logic            halt
);
    import cpu_pkg::*;

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] jump_pc;

    // All PC arithmetic wraps modulo 2^PC_W; imm8 is a signed word offset.
    assign seq_pc  = pc + PC_W'(1);
    assign offset  = PC_W'($signed(imm8));
    assign target  = seq_pc + offset;
    assign jump_pc = PC_W'(imm8);

    // Decode the opcode; a branch always loads the PC (taken or fall-through).
    always_comb begin
        pc_load = 1'b0;
        halt    = 1'b0;
        next_pc = seq_pc;
        if (en) begin
            case (opcode)
                OP_BEQ: begin
                    pc_load = 1'b1;
                    if (alu_eq) next_pc = target;
                end
                OP_BNE: begin
                    pc_load = 1'b1;
                    if (!alu_eq) next_pc = target;
                end
                OP_BLT: begin
                    pc_load = 1'b1;
                    if (!alu_eq && !alu_gt) next_pc = target;
                end
                OP_JMP: begin
                    pc_load = 1'b1;
                    next_pc = jump_pc;
                end
                OP_HLT: begin
                    halt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and IR, prefetches one instruction word
// and resolves branch/jump/halt in the cycle after each IR load.
//
// Memory handshake: imem_req is a one-cycle request for imem_addr (== pc).
// The memory answers with exactly one imem_valid pulse carrying imem_rdata,
// one or more cycles later. Only a response seen in WAIT is captured; a
// response coinciding with a PC change, or arriving outside WAIT, is dropped.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ir_write,
    input  logic               pc_write,
    input  logic               alu_eq,
    input  logic               alu_gt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [1:0]         rt,
    output logic [7:0]         imm8,
    output logic [PC_W-1:0]    pc,
    output logic               fetch_stall,
    output logic               halted,
    output logic [1:0]         dbg_state,
    output logic               dbg_buf_valid
);
    import cpu_pkg::*;

    logic [1:0]         state;
    logic [INSTR_W-1:0] buf_q;
    logic               buf_valid;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    pc_q;
    logic               halted_q;
    logic               ir_fresh;

    logic               load;
    logic               resolve_en;
    logic               br_pc_load;
    logic [PC_W-1:0]    br_next_pc;
    logic               br_halt;
    logic               pc_change;
    logic [PC_W-1:0]    pc_next;

    assign load       = ir_write && buf_valid && !halted_q;
    assign resolve_en = ir_fresh && !halted_q;

    branch_resolve #(.PC_W(PC_W)) u_branch_resolve (
        .en      (resolve_en),
        .opcode  (ir_opcode(ir_q)),
        .alu_eq  (alu_eq),
        .alu_gt  (alu_gt),
        .pc      (pc_q),
        .imm8    (ir_q[IMM_HI:IMM_LO]),
        .pc_load (br_pc_load),
        .next_pc (br_next_pc),
        .halt    (br_halt)
    );

    // Resolve wins over a simultaneous pc_write.
    assign pc_change = !halted_q && (br_pc_load || pc_write);
    assign pc_next   = br_pc_load ? br_next_pc : pc_q + PC_W'(1);

    // Prefetch FSM: any PC change restarts the request at the new address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
        end else if (halted_q) begin
            state <= state;
        end else if (pc_change) begin
            state <= ST_REQ;
        end else begin
            case (state)
                ST_REQ:  state <= ST_WAIT;
                ST_WAIT: if (imem_valid) state <= ST_FULL;
                ST_FULL: state <= ST_FULL;
                default: state <= ST_REQ;
            endcase
        end
    end

    // Prefetch buffer: filled by the memory response, emptied by an IR load or PC change.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            buf_valid <= 1'b0;
        end else if (!halted_q) begin
            if (pc_change || load) begin
                buf_valid <= 1'b0;
            end else if (state == ST_WAIT && imem_valid) begin
                buf_q     <= imem_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

    // IR load and the one-cycle "fresh" flag that opens the resolve cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= '0;
            ir_fresh <= 1'b0;
        end else begin
            if (load) ir_q <= buf_q;
            ir_fresh <= load;
        end
    end

    // PC register and sticky halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            if (pc_change) pc_q <= pc_next;
            if (br_halt) halted_q <= 1'b1;
        end
    end

    // Catch the FSM asserting pc_write in a resolve cycle that acts on the PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pc_write && (br_pc_load || br_halt)));
        end
    end

    assign imem_req      = (state == ST_REQ) && !halted_q && !rst;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign opcode        = ir_q[OPC_HI:OPC_LO];
    assign rd            = ir_q[RD_HI:RD_LO];
    assign rs            = ir_q[RS_HI:RS_LO];
    assign rt            = ir_q[RT_HI:RT_LO];
    assign imm8          = ir_q[IMM_HI:IMM_LO];
    assign fetch_stall   = ir_write && !buf_valid;
    assign halted        = halted_q;
    assign dbg_state     = state;
    assign dbg_buf_valid = buf_valid;

endmodule
